// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch sequencer for the 8-bit CPU. Owns the PC,
//                addresses a combinational instruction ROM, registers each
//                fetched word into a one-entry buffer and hands it to the
//                decoder over a valid/ready handshake. Handles jumps,
//                decoder backpressure and run/stop.
//                Optional halt detection is enabled by defining the macro
//                IFETCH_HALT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1
`ifdef IFETCH_HALT_EN
        ,
        HALT  = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0]  w_pc_next;
    logic [INSTR_W-1:0] w_instr_next;
    logic [ADDR_W-1:0]  w_instr_pc_next;
    logic               w_valid_next;
    logic               w_halt_load;
    logic               w_transfer;
    logic               w_load;
    logic               w_is_halt_word;

    // The ROM is combinational, so its address simply follows the PC.
    assign rom_addr   = pc;
    assign w_transfer = instr_valid & instr_ready;
    // A load may only refill the buffer when it is empty or being drained.
    assign w_load     = (r_state == FETCH) & en & ~jmp_valid
                        & (~instr_valid | w_transfer);

`ifdef IFETCH_HALT_EN
    assign w_is_halt_word = (rom_data[INSTR_W-1 -: 4] == HALT_OPCODE);
`else
    // Halt words are ordinary instructions in this build.
    assign w_is_halt_word = 1'b0;
    logic w_unused_halt_opcode;
    assign w_unused_halt_opcode = ^HALT_OPCODE;
`endif

    // Next-state and datapath decode; every target holds unless changed.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = pc;
        w_instr_next    = instr;
        w_instr_pc_next = instr_pc;
        w_valid_next    = instr_valid;
        w_halt_load     = 1'b0;

        case (r_state)
            IDLE: begin
                // A jump flushes the buffer; otherwise it drains normally.
                if (jmp_valid) begin
                    w_pc_next    = jmp_addr;
                    w_valid_next = 1'b0;
                end else if (w_transfer) begin
                    w_valid_next = 1'b0;
                end
                if (en) begin
                    w_state_next = FETCH;
                end
            end

            FETCH: begin
                if (jmp_valid) begin
                    w_pc_next    = jmp_addr;
                    w_valid_next = 1'b0;
                end else if (w_load) begin
                    w_instr_next    = rom_data;
                    w_instr_pc_next = pc;
                    w_valid_next    = 1'b1;
                    if (w_is_halt_word) begin
                        // PC stays on the halt address for debug visibility.
                        w_halt_load = 1'b1;
                    end else begin
                        w_pc_next = pc + ADDR_W'(1);
                    end
                end else if (w_transfer) begin
                    w_valid_next = 1'b0;
                end

                if (!en) begin
                    w_state_next = IDLE;
`ifdef IFETCH_HALT_EN
                end else if (w_halt_load) begin
                    w_state_next = HALT;
`endif
                end
            end

`ifdef IFETCH_HALT_EN
            HALT: begin
                // Jumps and en are ignored; only the buffered word may leave.
                if (w_transfer) begin
                    w_valid_next = 1'b0;
                end
            end
`endif

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC and output buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= START_ADDR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            pc          <= w_pc_next;
            instr       <= w_instr_next;
            instr_pc    <= w_instr_pc_next;
            instr_valid <= w_valid_next;
        end
    end

`ifdef IFETCH_HALT_EN
    // Halt flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (w_halt_load) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
    logic w_unused_halt_load;
    assign w_unused_halt_load = w_halt_load;
`endif

endmodule
`default_nettype wire
